vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller. Generates the pixel strobe, H/V counters, sync, blank and frame/line markers for any timing set, all from the single system clock.
- No derived clock domain: counters advance on a clock-enable strobe, and pixel_clk is a divided output for the video DAC only.
- Sits between the system clock and the color mapper / frame-buffer reader; DrawX/DrawY feed the drawing logic.

Parameters:
- CLK_DIV, 2: Clk cycles per pixel; even, >=2.
- CW, 10: width of DrawX/DrawY; totals must be <= 2^CW.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- H_SYNC_POL, 0: asserted level of hs (0 = active low).
- V_SYNC_POL, 0: asserted level of vs (0 = active low).
- FW, 8: width of frame_count.

Ports:
- Clk, in, 1: system clock, 50 MHz.
- Reset, in, 1: synchronous, active-high reset.
- pixel_ce, out, 1: one-Clk strobe marking the last Clk cycle of each pixel period.
- pixel_clk, out, 1: divided clock for the DAC, duty 50%.
- hs, out, 1: horizontal sync, polarity per H_SYNC_POL.
- vs, out, 1: vertical sync, polarity per V_SYNC_POL.
- blank, out, 1: active low; 1 = visible pixel.
- sync, out, 1: composite sync, tied 0.
- DrawX, out, CW: current horizontal position.
- DrawY, out, CW: current vertical position.
- line_start, out, 1: one-Clk pulse at the start of each line.
- frame_start, out, 1: one-Clk pulse at the start of each frame.
- frame_count, out, FW: completed-frame counter.

Behaviour:
- Clock and reset: all state is on posedge Clk. Reset is synchronous, active-high, and takes priority over all other logic.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 and 525.
- Divider: div counts 0..CLK_DIV-1 and wraps.
  - pixel_ce = (div == CLK_DIV-1).
  - pixel_clk = (div >= CLK_DIV/2).
  - Both are registered-state functions with no combinational path from Reset.
- Counters: on a cycle with pixel_ce=1:
  - If hc == H_TOTAL-1, hc <= 0; then if vc == V_TOTAL-1, vc <= 0, otherwise vc <= vc+1.
  - Otherwise hc <= hc+1.
  - hc and vc hold whenever pixel_ce=0.
- Position outputs: DrawX = hc, DrawY = vc. Each value holds for exactly CLK_DIV Clk cycles.
- Sync and blank are registered and aligned to the current (hc,vc): they change in the same Clk edge as the counters, with zero skew.
  - hs is asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vs is asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for whole lines.
  - blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
- Markers:
  - line_start = 1 for the single Clk cycle immediately after hc wraps to 0.
  - frame_start = 1 for the single Clk cycle immediately after (hc,vc) wraps to (0,0); it coincides with line_start.
  - frame_count increments by 1 in the same edge as the frame wrap and wraps at 2^FW-1 -> 0.
- Reset values: div=0, hc=0, vc=0, pixel_ce=0, pixel_clk=0, hs and vs at inactive level, blank=1, sync=0, line_start=0, frame_start=0, frame_count=0.
- Neither marker fires on reset release; the first frame_start follows the first full frame.
- Reset mid-line or mid-frame: the next cycle shows the reset values, and counting restarts at (0,0) with a full CLK_DIV period before the first advance.
- Simultaneous end of line and end of frame: both counters wrap in the same edge, and both markers fire in the following cycle.
- Width rule: compare in CW bits. Counters never exceed H_TOTAL-1 / V_TOTAL-1, so no overflow is possible.

Test Plan:
- Defaults, release reset, run one frame:
  - pixel_ce pattern 0,1,0,1.
  - DrawX steps every 2 Clk, 0..799.
  - DrawY 0..524, then both return to 0.
  - First frame_start occurs exactly 2*800*525 = 840000 Clk after release.
- Defaults, scan line 0:
  - hs = 0 exactly for DrawX 656..751 (96 pixels = 192 Clk).
  - blank = 1 for DrawX 0..639 and 0 from 640.
- Defaults, scan the frame:
  - vs = 0 only for DrawY 490..491.
  - blank = 0 for every pixel with DrawY >= 480.
- Small config (CLK_DIV=4, H = 4/1/2/1, V = 3/1/1/1, H_SYNC_POL=1):
  - Line = 32 Clk; hs = 1 at hc 5..6.
  - Frame = 192 Clk; frame_count = 3 after 3 frames.
  - pixel_clk high for div 2..3.
- Assert Reset for 1 cycle at (hc,vc) = (700,300), defaults:
  - Next cycle DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 1, frame_count = 0.
  - No line_start or frame_start pulse.
- FW=2, run 5 frames: frame_count sequence 1,2,3,0,1, each changing in the same Clk as the frame wrap.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel strobe, H/V counters, sync, blank
// and line/frame markers, all clocked from the single system clock.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int CW         = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int FW         = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          pixel_ce,
  output logic          pixel_clk,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          H_ON     = (H_SYNC_POL != 0);
  localparam logic          V_ON     = (V_SYNC_POL != 0);

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_hc, r_vc;
  logic          r_hs, r_vs, r_blank, r_ls, r_fs;
  logic [FW-1:0] r_fc;

  logic [CW-1:0] w_hc_nxt, w_vc_nxt;
  logic          w_hwrap, w_fwrap;

  function automatic logic hs_level(input logic [CW-1:0] hc);
    return ((hc >= H_SS) && (hc < H_SE)) ? H_ON : ~H_ON;
  endfunction

  function automatic logic vs_level(input logic [CW-1:0] vc);
    return ((vc >= V_SS) && (vc < V_SE)) ? V_ON : ~V_ON;
  endfunction

  assign pixel_ce  = (r_div == DIV_LAST);
  assign pixel_clk = (r_div >= DIV_HALF);

  always_comb begin
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    w_hwrap  = 1'b0;
    w_fwrap  = 1'b0;
    if (pixel_ce) begin
      if (r_hc == H_LAST) begin
        w_hc_nxt = '0;
        w_hwrap  = 1'b1;
        if (r_vc == V_LAST) begin
          w_vc_nxt = '0;
          w_fwrap  = 1'b1;
        end else begin
          w_vc_nxt = r_vc + 1'b1;
        end
      end else begin
        w_hc_nxt = r_hc + 1'b1;
      end
    end
  end

  // Sync/blank are decoded from the next counter values so they land on the
  // same edge as the counters themselves.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div   <= '0;
      r_hc    <= '0;
      r_vc    <= '0;
      r_hs    <= ~H_ON;
      r_vs    <= ~V_ON;
      r_blank <= 1'b1;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_div   <= pixel_ce ? '0 : r_div + 1'b1;
      r_hc    <= w_hc_nxt;
      r_vc    <= w_vc_nxt;
      r_hs    <= hs_level(w_hc_nxt);
      r_vs    <= vs_level(w_vc_nxt);
      r_blank <= (w_hc_nxt < H_ACT) && (w_vc_nxt < V_ACT);
      r_ls    <= w_hwrap;
      r_fs    <= w_fwrap;
      if (w_fwrap) r_fc <= r_fc + 1'b1;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_count = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three timing configurations driven by a shared random
// reset, each compared every cycle against an arithmetic timing model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        ce, pclk, hs, vs, blank, sync, ls, fs;
    logic [15:0] x, y, fc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // small configuration
  localparam int S_CD = 4, S_CW = 4, S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1, S_HP = 1, S_VP = 0, S_FW = 2;
  // medium configuration
  localparam int M_CD = 2, M_CW = 5, M_HA = 10, M_HF = 2, M_HS = 3, M_HB = 5;
  localparam int M_VA = 5, M_VF = 2, M_VS = 2, M_VB = 3, M_HP = 0, M_VP = 1, M_FW = 3;
  // default 640x480 configuration
  localparam int D_CD = 2, D_CW = 10, D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VB = 33, D_HP = 0, D_VP = 0, D_FW = 8;

  logic s_ce, s_pc, s_hs, s_vs, s_bl, s_sy, s_ls, s_fs;
  logic [S_CW-1:0] s_x, s_y;
  logic [S_FW-1:0] s_fc;
  logic m_ce, m_pc, m_hs, m_vs, m_bl, m_sy, m_ls, m_fs;
  logic [M_CW-1:0] m_x, m_y;
  logic [M_FW-1:0] m_fc;
  logic d_ce, d_pc, d_hs, d_vs, d_bl, d_sy, d_ls, d_fs;
  logic [D_CW-1:0] d_x, d_y;
  logic [D_FW-1:0] d_fc;

  vga_timing_gen #(.CLK_DIV(S_CD), .CW(S_CW), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS),
    .H_BP(S_HB), .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_SYNC_POL(S_HP), .V_SYNC_POL(S_VP), .FW(S_FW)) u_small (
    .Clk(Clk), .Reset(Reset), .pixel_ce(s_ce), .pixel_clk(s_pc), .hs(s_hs), .vs(s_vs),
    .blank(s_bl), .sync(s_sy), .DrawX(s_x), .DrawY(s_y), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc));

  vga_timing_gen #(.CLK_DIV(M_CD), .CW(M_CW), .H_ACTIVE(M_HA), .H_FP(M_HF), .H_SYNC(M_HS),
    .H_BP(M_HB), .V_ACTIVE(M_VA), .V_FP(M_VF), .V_SYNC(M_VS), .V_BP(M_VB),
    .H_SYNC_POL(M_HP), .V_SYNC_POL(M_VP), .FW(M_FW)) u_mid (
    .Clk(Clk), .Reset(Reset), .pixel_ce(m_ce), .pixel_clk(m_pc), .hs(m_hs), .vs(m_vs),
    .blank(m_bl), .sync(m_sy), .DrawX(m_x), .DrawY(m_y), .line_start(m_ls),
    .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen u_def (
    .Clk(Clk), .Reset(Reset), .pixel_ce(d_ce), .pixel_clk(d_pc), .hs(d_hs), .vs(d_vs),
    .blank(d_bl), .sync(d_sy), .DrawX(d_x), .DrawY(d_y), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc));

  // t = Clk edges since the last edge that sampled Reset high
  function automatic exp_t model(input int t, input int cd, input int ha, input int hf,
                                 input int hsw, input int hb, input int va, input int vf,
                                 input int vsw, input int vb, input int hp, input int vp,
                                 input int fw);
    exp_t e;
    int ht, vt, dv, p, hc, vc, fr;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    dv = t % cd;
    p  = t / cd;
    hc = p % ht;
    vc = (p / ht) % vt;
    fr = p / (ht * vt);
    e.ce    = (dv == cd - 1);
    e.pclk  = (dv >= cd / 2);
    e.hs    = (hc >= ha + hf && hc < ha + hf + hsw) ? (hp != 0) : (hp == 0);
    e.vs    = (vc >= va + vf && vc < va + vf + vsw) ? (vp != 0) : (vp == 0);
    e.blank = (hc < ha) && (vc < va);
    e.sync  = 1'b0;
    e.ls    = (dv == 0) && (hc == 0) && (p > 0);
    e.fs    = (dv == 0) && (hc == 0) && (vc == 0) && (p > 0);
    e.x     = 16'(hc);
    e.y     = 16'(vc);
    e.fc    = 16'(fr % (1 << fw));
    return e;
  endfunction

  function automatic exp_t pack(input logic ce, input logic pc, input logic h, input logic v,
                                input logic bl, input logic sy, input logic ls, input logic fs,
                                input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] fc);
    exp_t e;
    e = '{ce: ce, pclk: pc, hs: h, vs: v, blank: bl, sync: sy, ls: ls, fs: fs,
          x: x, y: y, fc: fc};
    return e;
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got ce%b pc%b hs%b vs%b bl%b sy%b ls%b fs%b x=%0d y=%0d fc=%0d | want ce%b pc%b hs%b vs%b bl%b sy%b ls%b fs%b x=%0d y=%0d fc=%0d",
               nm, $time, got.ce, got.pclk, got.hs, got.vs, got.blank, got.sync, got.ls,
               got.fs, got.x, got.y, got.fc, exp.ce, exp.pclk, exp.hs, exp.vs, exp.blank,
               exp.sync, exp.ls, exp.fs, exp.x, exp.y, exp.fc);
    end
  endtask

  exp_t q_s[$], q_m[$], q_d[$];

  // Monitor: compare each DUT one time unit after the edge it was predicted for.
  always @(posedge Clk) begin
    #1;
    if (q_s.size() > 0)
      check("small", pack(s_ce, s_pc, s_hs, s_vs, s_bl, s_sy, s_ls, s_fs,
                          16'(s_x), 16'(s_y), 16'(s_fc)), q_s.pop_front());
    if (q_m.size() > 0)
      check("mid", pack(m_ce, m_pc, m_hs, m_vs, m_bl, m_sy, m_ls, m_fs,
                        16'(m_x), 16'(m_y), 16'(m_fc)), q_m.pop_front());
    if (q_d.size() > 0)
      check("default", pack(d_ce, d_pc, d_hs, d_vs, d_bl, d_sy, d_ls, d_fs,
                            16'(d_x), 16'(d_y), 16'(d_fc)), q_d.pop_front());
  end

  initial begin
    int t;
    int rst_left;
    t = 0;
    rst_left = 3;
    for (int i = 0; i < 30000; i++) begin
      @(negedge Clk);
      if (rst_left == 0) begin
        if (i == 15001 || $urandom_range(3999, 0) == 0) rst_left = $urandom_range(3, 1);
      end
      Reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      t = Reset ? 0 : t + 1;
      q_s.push_back(model(t, S_CD, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                          S_HP, S_VP, S_FW));
      q_m.push_back(model(t, M_CD, M_HA, M_HF, M_HS, M_HB, M_VA, M_VF, M_VS, M_VB,
                          M_HP, M_VP, M_FW));
      q_d.push_back(model(t, D_CD, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB,
                          D_HP, D_VP, D_FW));
    end
    repeat (3) @(negedge Clk);
    total++;
    if (q_s.size() + q_m.size() + q_d.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want 0", q_s.size() + q_m.size() + q_d.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
